// File: rtl/koggestone_adder8.sv
// koggestone_adder8: 8-bit Kogge-Stone prefix adder with a registered sum; uio bus is input-only.
module koggestone_black_cell (
    input  logic i_g_hi,
    input  logic i_p_hi,
    input  logic i_g_lo,
    input  logic i_p_lo,
    output logic o_g,
    output logic o_p
);
    assign o_g = i_g_hi | (i_p_hi & i_g_lo);
    assign o_p = i_p_hi & i_p_lo;
endmodule

module koggestone_adder8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    logic [3:0][7:0] w_g;
    logic [3:0][7:0] w_p;
    logic [8:0]      w_c;
    logic [7:0]      w_s;
    logic [7:0]      r_sum;
    logic            w_unused;

    assign w_g[0] = ui_in & uio_in;
    assign w_p[0] = ui_in ^ uio_in;

    // Level l combines each bit with the group 2**l positions below it.
    for (genvar l = 0; l < 3; l++) begin : g_lvl
        for (genvar i = 0; i < 8; i++) begin : g_bit
            if (i >= (1 << l)) begin : g_cell
                koggestone_black_cell u_cell (
                    .i_g_hi(w_g[l][i]),
                    .i_p_hi(w_p[l][i]),
                    .i_g_lo(w_g[l][i-(1<<l)]),
                    .i_p_lo(w_p[l][i-(1<<l)]),
                    .o_g   (w_g[l+1][i]),
                    .o_p   (w_p[l+1][i])
                );
            end else begin : g_pass
                assign w_g[l+1][i] = w_g[l][i];
                assign w_p[l+1][i] = w_p[l][i];
            end
        end
    end

    assign w_c = {w_g[3], 1'b0};
    assign w_s = w_p[0] ^ w_c[7:0];
    // Carry-out and final-level propagates are not needed for the wrapped sum.
    assign w_unused = ^{w_c[8], w_p[3]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_sum <= 8'h00;
        else if (ena)
            r_sum <= w_s;
    end

    assign uo_out  = r_sum;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;
endmodule

// File: tb/tb_koggestone_adder8.sv
// tb_koggestone_adder8: directed, random and exhaustive checks against an arithmetic model.
module tb_koggestone_adder8;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;
    int vectors = 0;
    int errors = 0;

    koggestone_adder8 dut (
        .clk(clk), .rst(rst), .ena(ena),
        .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b);
        int s;
        s = int'(a) + int'(b);
        return 8'(s % 256);
    endfunction

    task automatic step(input logic [7:0] a, input logic [7:0] b);
        ui_in = a;
        uio_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ena = 1'b1;
        ui_in = 8'hFF;
        uio_in = 8'h01;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (uo_out !== 8'h00) begin errors++; $display("FAIL reset uo_out got %h exp 00", uo_out); end
        vectors++;
        if (uio_oe !== 8'h00) begin errors++; $display("FAIL reset uio_oe got %h exp 00", uio_oe); end
        vectors++;
        if (uio_out !== 8'h00) begin errors++; $display("FAIL reset uio_out got %h exp 00", uio_out); end
        #3 rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [7:0] ta [8] = '{8'd25, 8'd0, 8'hFF, 8'h7F, 8'h0F, 8'hFF, 8'h80, 8'hAA};
        logic [7:0] tb [8] = '{8'd17, 8'd0, 8'h01, 8'h01, 8'h01, 8'hFF, 8'h80, 8'h55};
        logic [7:0] te [8] = '{8'd42, 8'h00, 8'h00, 8'h80, 8'h10, 8'hFE, 8'h00, 8'hFF};
        ena = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step(ta[k], tb[k]);
            vectors++;
            if (uo_out !== te[k] || uo_out !== model(ta[k], tb[k])) begin
                errors++;
                $display("FAIL directed %h+%h got %h exp %h", ta[k], tb[k], uo_out, te[k]);
            end
        end
    endtask

    task automatic test_hold_reset();
        ena = 1'b1;
        step(8'd100, 8'd50);
        vectors++;
        if (uo_out !== 8'd150) begin errors++; $display("FAIL load got %0d exp 150", uo_out); end
        ena = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(8'd1, 8'd1);
            vectors++;
            if (uo_out !== 8'd150) begin errors++; $display("FAIL hold got %0d exp 150", uo_out); end
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (uo_out !== 8'h00) begin errors++; $display("FAIL async_reset got %h exp 00", uo_out); end
        ena = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (uo_out !== 8'h00) begin errors++; $display("FAIL reset_wins got %h exp 00", uo_out); end
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (uo_out !== 8'd2) begin errors++; $display("FAIL post_reset got %0d exp 2", uo_out); end
    endtask

    task automatic test_random();
        logic [7:0] exp_q = uo_out;
        logic [7:0] a, b;
        for (int k = 0; k < 300; k++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            ena = ($urandom_range(0, 3) != 0);
            if (ena) exp_q = model(a, b);
            step(a, b);
            vectors++;
            if (uo_out !== exp_q) begin
                errors++;
                $display("FAIL random %h+%h ena=%b got %h exp %h", a, b, ena, uo_out, exp_q);
            end
        end
        ena = 1'b1;
    endtask

    task automatic test_back_to_back();
        ena = 1'b1;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                step(8'(a), 8'(b));
                vectors++;
                if (uo_out !== model(8'(a), 8'(b))) begin
                    errors++;
                    $display("FAIL exhaustive %h+%h got %h exp %h", a[7:0], b[7:0], uo_out, model(8'(a), 8'(b)));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold_reset();
        test_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
